fpu_issue_controller: RTL and testbench

Issue-side controller for the fixed-point unit. It accepts one arithmetic request at a time from the execute stage and drives the fixed-point unit's operation and operand inputs. It qualifies the unit's `ready` against per-operation minimum latencies, captures the result, and returns it with its destination tag over a valid/ready response channel. It also bounds every operation with a timeout so the core never deadlocks on a hung unit.

---
 rtl/fpu_issue_controller.sv | 151 +++++++++++++++
 tb/tb_fpu_issue_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_controller.sv
// Issue-side controller for the fixed-point unit: one request in flight, per-op minimum
// latency qualification of fpu_ready, timeout abort, and a valid/ready response channel.
module fpu_issue_controller #(
    parameter int WIDTH         = 32,
    parameter int TAG_WIDTH     = 5,
    parameter int MUL_MIN_WAIT  = 6,
    parameter int SQRT_MIN_WAIT = 3,
    parameter int TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [WIDTH-1:0]     req_operand_1,
    input  logic [WIDTH-1:0]     req_operand_2,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic [1:0]           fpu_operation,
    output logic [WIDTH-1:0]     fpu_operand_1,
    output logic [WIDTH-1:0]     fpu_operand_2,
    input  logic [WIDTH-1:0]     fpu_result,
    input  logic                 fpu_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_error,
    output logic                 busy
);
    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [1:0]             op_reg;
    logic [WIDTH-1:0]       operand_1_reg;
    logic [WIDTH-1:0]       operand_2_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;
    logic [CNT_W-1:0]       wait_cnt_reg;
    logic                   req_ready_reg;
    logic                   busy_reg;
    logic                   rsp_valid_reg;
    logic [WIDTH-1:0]       rsp_result_reg;
    logic [TAG_WIDTH-1:0]   rsp_tag_reg;
    logic                   rsp_error_reg;

    // Minimum WAIT cycle before fpu_ready is trusted, indexed by operation code.
    logic [CNT_W-1:0] min_wait_table [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_min_wait
            localparam int MW = (gi == int'(FPU_MUL))  ? MUL_MIN_WAIT  :
                                (gi == int'(FPU_SQRT)) ? SQRT_MIN_WAIT : 1;
            assign min_wait_table[gi] = CNT_W'(MW);
        end
    endgenerate

    logic [CNT_W-1:0] min_wait;
    logic             done;

    assign min_wait = min_wait_table[op_reg];
    // A stale fpu_ready from the previous operation is masked until min_wait is reached.
    assign done     = fpu_ready && (wait_cnt_reg >= min_wait);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            op_reg         <= FPU_ADD;
            operand_1_reg  <= '0;
            operand_2_reg  <= '0;
            tag_reg        <= '0;
            wait_cnt_reg   <= '0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_tag_reg    <= '0;
            rsp_error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg        <= req_op;
                        operand_1_reg <= req_operand_1;
                        operand_2_reg <= req_operand_2;
                        tag_reg       <= req_tag;
                        wait_cnt_reg  <= CNT_ONE;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        rsp_result_reg <= fpu_result;
                        rsp_error_reg  <= 1'b0;
                        rsp_tag_reg    <= tag_reg;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                        rsp_result_reg <= '0;
                        rsp_error_reg  <= 1'b1;
                        rsp_tag_reg    <= tag_reg;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                    end
                end
                RESP: begin
                    // Parking the unit on ADD with zero operands keeps MUL/SQRT sequencers idle.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        op_reg        <= FPU_ADD;
                        operand_1_reg <= '0;
                        operand_2_reg <= '0;
                        wait_cnt_reg  <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_reg;
    assign busy          = busy_reg;
    assign fpu_operation = op_reg;
    assign fpu_operand_1 = operand_1_reg;
    assign fpu_operand_2 = operand_2_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_tag       = rsp_tag_reg;
    assign rsp_error     = rsp_error_reg;

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Scoreboard bench for fpu_issue_controller with a small behavioural model of the unit.
module tb_fpu_issue_controller;
    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 5;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [1:0]           req_op = '0;
    logic [WIDTH-1:0]     req_operand_1 = '0;
    logic [WIDTH-1:0]     req_operand_2 = '0;
    logic [TAG_WIDTH-1:0] req_tag = '0;
    logic [1:0]           fpu_operation;
    logic [WIDTH-1:0]     fpu_operand_1;
    logic [WIDTH-1:0]     fpu_operand_2;
    logic [WIDTH-1:0]     fpu_result = '0;
    logic                 fpu_ready = 1'b0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [WIDTH-1:0]     rsp_result;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 rsp_error;
    logic                 busy;

    fpu_issue_controller dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_operand_1(req_operand_1), .req_operand_2(req_operand_2), .req_tag(req_tag),
        .fpu_operation(fpu_operation), .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]           op;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
        logic [TAG_WIDTH-1:0] tag;
        logic [WIDTH-1:0]     result;
        logic                 err;
        logic [7:0]           lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Unit model knobs: ready from WAIT cycle model_ready_at (or always if stale),
    // model_value presented from WAIT cycle model_val_at, junk before that.
    logic             model_stale    = 1'b0;
    int               model_ready_at = 1000;
    int               model_val_at   = 1000;
    logic [WIDTH-1:0] model_value    = '0;

    bit   in_op = 1'b0;
    bit   rise_seen = 1'b0;
    bit   hs_prev = 1'b0;
    int   acc_cyc = 0;
    int   rise_w = 0;
    int   mw = 0;
    exp_t cur;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog: got cycle %0d expected below 20000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            in_op     = 1'b0;
            rise_seen = 1'b0;
            hs_prev   = 1'b0;
        end else begin
            if (hs_prev) begin
                check_val("req_ready_after_hs", req_ready, 1);
                check_val("park_op", fpu_operation, OP_ADD);
                check_val("park_opnd1", fpu_operand_1, 0);
                check_val("park_opnd2", fpu_operand_2, 0);
                hs_prev = 1'b0;
            end
            mw = cyc - acc_cyc + 1;
            if (in_op && mw == 1 && sb.size() != 0) begin
                cur = sb[0];
                check_val("wait_fpu_op", fpu_operation, cur.op);
                check_val("wait_fpu_opnd1", fpu_operand_1, cur.a);
                check_val("wait_fpu_opnd2", fpu_operand_2, cur.b);
                check_val("wait_busy", busy, 1);
                check_val("wait_req_ready", req_ready, 0);
            end
            if (in_op && rsp_valid && !rise_seen) begin
                rise_seen = 1'b1;
                rise_w    = mw;
            end
            if (rsp_valid && rsp_ready) begin
                check_val("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check_val("rsp_result", rsp_result, cur.result);
                    check_val("rsp_tag", rsp_tag, cur.tag);
                    check_val("rsp_error", rsp_error, cur.err);
                    check_val("rsp_latency", rise_w, cur.lat);
                    $display("txn op=%0d tag=%0d result=0x%0h error=%0b rsp_cycle=%0d",
                             cur.op, rsp_tag, rsp_result, rsp_error, rise_w);
                end
                in_op     = 1'b0;
                rise_seen = 1'b0;
                hs_prev   = 1'b1;
            end
            if (req_valid && req_ready) begin
                in_op   = 1'b1;
                acc_cyc = cyc + 1;
            end
        end
        mw = in_op ? (cyc - acc_cyc + 1) : 0;
        fpu_ready  = model_stale || (in_op && mw >= 1 && mw >= model_ready_at);
        fpu_result = (in_op && mw >= 1 && mw >= model_val_at) ? model_value : 32'hBAD0_BAD0;
    end

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_WIDTH-1:0] tag, input logic [WIDTH-1:0] res,
                         input logic err, input logic [7:0] lat);
        exp_t e;
        e = '{op: op, a: a, b: b, tag: tag, result: res, err: err, lat: lat};
        sb.push_back(e);
        req_valid     = 1'b1;
        req_op        = op;
        req_operand_1 = a;
        req_operand_2 = b;
        req_tag       = tag;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_op        = 2'($urandom);
        req_operand_1 = $urandom;
        req_operand_2 = $urandom;
        req_tag       = TAG_WIDTH'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && (in_op || rsp_valid); i++) begin
            @(posedge clk); #1;
        end
        check_val({"complete_", tag}, in_op || rsp_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_req_ready"}, req_ready, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_rsp_valid"}, rsp_valid, 0);
        check_val({tag, "_rsp_result"}, rsp_result, 0);
        check_val({tag, "_rsp_tag"}, rsp_tag, 0);
        check_val({tag, "_rsp_error"}, rsp_error, 0);
        check_val({tag, "_fpu_op"}, fpu_operation, OP_ADD);
        check_val({tag, "_fpu_opnd1"}, fpu_operand_1, 0);
        check_val({tag, "_fpu_opnd2"}, fpu_operand_2, 0);
    endtask

    initial begin
        logic [WIDTH-1:0]     snap_result;
        logic [TAG_WIDTH-1:0] snap_tag;
        logic                 snap_error;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        reset_checks("reset");

        // ADD 1.5 + 2.0, unit ready immediately
        model_stale = 1'b1; model_ready_at = 1; model_val_at = 1; model_value = 32'hE00;
        issue(OP_ADD, 32'h600, 32'h800, 5'd3, 32'hE00, 1'b0, 8'd2);
        wait_done("add", 20);

        // MUL with stale ready; real result only from WAIT cycle 6
        model_stale = 1'b1; model_ready_at = 1; model_val_at = 6; model_value = 32'hC00;
        issue(OP_MUL, 32'h600, 32'h800, 5'd5, 32'hC00, 1'b0, 8'd7);
        wait_done("mul", 30);

        // SQRT 4.0, unit ready at WAIT cycle 20
        model_stale = 1'b0; model_ready_at = 20; model_val_at = 20; model_value = 32'h800;
        issue(OP_SQRT, 32'h1000, 32'h0, 5'd12, 32'h800, 1'b0, 8'd21);
        wait_done("sqrt", 60);

        // SUB against a hung unit
        model_stale = 1'b0; model_ready_at = 1000; model_val_at = 1000; model_value = 32'h0;
        issue(OP_SUB, 32'h900, 32'h100, 5'd21, 32'h0, 1'b1, 8'd65);
        wait_done("timeout", 200);
        check_val("timeout_idle_busy", busy, 0);

        // Backpressure on the response channel
        model_stale = 1'b1; model_ready_at = 1; model_val_at = 1; model_value = 32'h300;
        rsp_ready = 1'b0;
        issue(OP_ADD, 32'h100, 32'h200, 5'd9, 32'h300, 1'b0, 8'd2);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check_val("bp_rsp_valid", rsp_valid, 1);
        snap_result = rsp_result;
        snap_tag    = rsp_tag;
        snap_error  = rsp_error;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_valid_hold", rsp_valid, 1);
            check_val("bp_result_hold", rsp_result, snap_result);
            check_val("bp_tag_hold", rsp_tag, snap_tag);
            check_val("bp_error_hold", rsp_error, snap_error);
            check_val("bp_req_ready", req_ready, 0);
            check_val("bp_fpu_op", fpu_operation, OP_ADD);
            check_val("bp_fpu_opnd1", fpu_operand_1, 32'h100);
        end
        rsp_ready = 1'b1;
        wait_done("bp", 10);

        // Reset in the middle of a MUL
        model_stale = 1'b0; model_ready_at = 1000; model_val_at = 1000; model_value = 32'hC00;
        issue(OP_MUL, 32'h600, 32'h800, 5'd4, 32'hC00, 1'b0, 8'd7);
        repeat (3) @(posedge clk);
        #1 check_val("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        reset_checks("midrst");

        model_stale = 1'b1; model_ready_at = 1; model_val_at = 1; model_value = 32'hE00;
        issue(OP_ADD, 32'h600, 32'h800, 5'd7, 32'hE00, 1'b0, 8'd2);
        wait_done("post_reset_add", 20);
        check_val("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
